agusec_bounds_enc: RTL
======================

Name: agusec_bounds_enc

Overview:
- Encoder for the fat-pointer security fields consumed by the AGU bounds checker.
- Takes a byte base, byte length and cursor, searches for the smallest exponent whose 8-bit window covers the granule range, and emits a 64-bit pointer with exp/hi/low/on_low fields.
- Sits behind the capability set-bounds micro-op. Its output pointer must pass the checker for every address in the encoded window.

Parameters:
- MAX_EXP, 31: exponent value meaning "unbounded"; searched exponents are 0..MAX_EXP-1.
- GRAN_LSB, 4: granule shift; bounds are in 16-byte granules, so address[43:4] is the granule index.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_vld  in  1  request valid
- in_rdy  out  1  request accepted when in_vld&in_rdy
- in_base  in  44  byte base address
- in_len  in  44  byte length
- in_cursor  in  44  byte address placed in ptr[43:0]
- out_vld  out  1  result valid
- out_rdy  in  1  result consumed when out_vld&out_rdy
- out_ptr  out  64  {exp[63:59],hi7[58:52],low7[51:45],on_low[44],cursor[43:0]}
- out_exact  out  1  encoded bounds equal requested bounds exactly
- out_err  out  1  cursor lies outside the encoded window
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; in_rdy=1; out_vld=0; out_ptr=0; out_exact=0; out_err=0; busy=0.
- On accept, latch the following:
  - b = base[43:4] (40 bits).
  - t = (base+len+15)[44:4] (41 bits; the 45-bit sum never wraps).
  - c = cursor[43:4].
  - zl = (len==0).
- Per tested exponent e:
  - lo = (b>>e)&~1.
  - hi = zl ? lo|1 : ((t-1)>>e)|1.
  - fit = (hi-lo) <= 255.
- FSM states: IDLE, SEARCH, FINAL, DONE.
  - IDLE: in_rdy=1. On accept go to SEARCH with e=0.
  - SEARCH: tests one e per cycle.
    - If fit, capture e and go to FINAL.
    - Else if e==MAX_EXP-1, capture exp=MAX_EXP and go to FINAL.
    - Else e++.
  - FINAL (bounded exp): register the fields.
    - exp = e; low7 = lo[7:1]; hi7 = hi[7:1].
    - exact = zl | ((lo<<e)==b && ((hi+1)<<e)==t).
    - cw = c>>e; err = (cw<lo) | (cw>hi).
    - on_low = ((cw>>8)==(lo>>8)).
    - Go to DONE.
  - FINAL (exp==MAX_EXP): low7=0, hi7=7F, on_low=1, exact=0, err=0. Go to DONE.
  - DONE: out_vld=1 with outputs stable until out_rdy. On handshake go to IDLE with out_vld=0 in the same edge.
- in_rdy is low in SEARCH, FINAL and DONE. A new request is accepted only the cycle after the output handshake; no bypass.
- Latency: for the accept edge at cycle 0, out_vld is high from cycle e+3. For the unbounded case, out_vld is high from cycle MAX_EXP+2.
- Wrap case (hi7<low7): hi-lo crosses a 256 boundary. on_low distinguishes the lower block (cursor window block equals lo's block) from the upper one.
- rst asserted in any state aborts the search and restores the reset values. A partially searched request is dropped with no output.
- in_* values are ignored except on the accept edge. Registered copies are used throughout the search.

Decomposition:
- agusec_pkg holds:
  - field positions: PTR_EXP 63:59, PTR_HI 58:52, PTR_LOW 51:45, PTR_ON_LOW 44, PTR_ADDR 43:0;
  - the granule shift;
  - the MAX_EXP constant;
  - the FSM state enum.
- One combinational sub-module, agusec_enc_fit:
  - inputs: e, b, t, zl;
  - outputs: lo, hi, fit, exact.
  - Shared by SEARCH (fit) and FINAL (fields).

Test Plan:
- base=0x1000, len=0x100, cursor=0x1040 -> exp=0, low7=0x00, hi7=0x07, on_low=1, exact=1, err=0; out_vld high at cycle 3.
- base=0x0, len=0x10000, cursor=0x0 -> exp=4, low7=0x00, hi7=0x7F, exact=1; out_vld at cycle 7.
- base=0x18, len=0x1000, cursor=0x18 -> e=0 fails (span 257); exp=1, low7=0x00, hi7=0x40, exact=0.
- base=0x0, len=0xFFF_FFFF_FFF0 -> no fit through e=30; exp=31, hi7=0x7F, low7=0, exact=0; out_vld at cycle 33.
- len=0, base=0x2230 -> exp=0, low7=hi7=0x11, exact=1. Cursor=0x3000 gives err=1.
- Backpressure and reset:
  - Hold out_rdy=0 for 5 cycles: out_ptr is stable, in_rdy stays 0, and a second in_vld is not accepted until one cycle after the handshake.
  - Assert rst mid-SEARCH: out_vld=0, busy=0, in_rdy=1 immediately; no stale output afterwards.

Source files
------------

// File: rtl/agusec_pkg.sv
// Shared constants, pointer field layout and FSM state type for the AGU bounds encoder.
package agusec_pkg;

    localparam int unsigned ADDR_W   = 44;
    localparam int unsigned GRAN_LSB = 4;
    localparam int unsigned GRAN_W   = ADDR_W - GRAN_LSB;
    localparam int unsigned MAX_EXP  = 31;
    localparam int unsigned EXP_W    = 5;
    localparam int unsigned PTR_W    = 64;

    localparam int unsigned PTR_EXP_MSB = 63;
    localparam int unsigned PTR_EXP_LSB = 59;
    localparam int unsigned PTR_HI_MSB  = 58;
    localparam int unsigned PTR_HI_LSB  = 52;
    localparam int unsigned PTR_LOW_MSB = 51;
    localparam int unsigned PTR_LOW_LSB = 45;
    localparam int unsigned PTR_ON_LOW  = 44;
    localparam int unsigned PTR_ADDR_MSB = 43;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StFinal,
        StDone
    } state_e;

endpackage

// File: rtl/agusec_enc_fit.sv
// Window evaluation for one exponent: aligned low/high granule bounds, fit test and exactness.
module agusec_enc_fit
    import agusec_pkg::*;
(
    input  logic [EXP_W-1:0]  e,
    input  logic [GRAN_W-1:0] b,
    input  logic [GRAN_W:0]   t,
    input  logic              zl,
    output logic [GRAN_W-1:0] lo,
    output logic [GRAN_W:0]   hi,
    output logic              fit,
    output logic              exact
);

    logic [GRAN_W:0] t_m1;
    logic [GRAN_W:0] span;
    // Wide enough that a 41-bit bound shifted back up by any exponent cannot overflow.
    logic [71:0]     lo_w;
    logic [71:0]     hi_w;

    always_comb begin
        t_m1  = t - (GRAN_W + 1)'(1);
        lo    = (b >> e) & ~GRAN_W'(1);
        hi    = zl ? ({1'b0, lo} | (GRAN_W + 1)'(1)) : ((t_m1 >> e) | (GRAN_W + 1)'(1));
        span  = hi - {1'b0, lo};
        fit   = (span <= (GRAN_W + 1)'(255));
        lo_w  = {32'd0, lo} << e;
        hi_w  = ({31'd0, hi} + 72'd1) << e;
        exact = zl | ((lo_w == {32'd0, b}) & (hi_w == {31'd0, t}));
    end

endmodule

// File: rtl/agusec_bounds_enc.sv
// Fat-pointer bounds encoder: iterative search for the smallest exponent whose window covers
// the requested granule range, then registers the exp/hi/low/on_low fields and cursor.
module agusec_bounds_enc
    import agusec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] in_len,
    input  logic [ADDR_W-1:0] in_cursor,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [PTR_W-1:0]  out_ptr,
    output logic              out_exact,
    output logic              out_err,
    output logic              busy
);

    localparam logic [EXP_W-1:0] ExpUnb  = EXP_W'(MAX_EXP);
    localparam logic [EXP_W-1:0] ExpLast = EXP_W'(MAX_EXP - 1);

    state_e            state_q, state_d;
    logic [EXP_W-1:0]  e_q, e_d;
    logic [GRAN_W-1:0] b_q;
    logic [GRAN_W:0]   t_q;
    logic              zl_q;
    logic [ADDR_W-1:0] cursor_q;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              exact_q, exact_d;
    logic              err_q, err_d;
    logic              load;

    logic [GRAN_W-1:0] lo;
    logic [GRAN_W:0]   hi;
    logic              fit;
    logic              exact;
    logic [GRAN_W-1:0] cw;
    logic              cw_err;
    logic              cw_on_low;

    agusec_enc_fit u_fit (
        .e     (e_q),
        .b     (b_q),
        .t     (t_q),
        .zl    (zl_q),
        .lo    (lo),
        .hi    (hi),
        .fit   (fit),
        .exact (exact)
    );

    // Cursor in window units; on_low picks which 256-block of a wrapping window it sits in.
    always_comb begin
        cw        = cursor_q[ADDR_W-1:GRAN_LSB] >> e_q;
        cw_err    = (cw < lo) | ({1'b0, cw} > hi);
        cw_on_low = (cw[GRAN_W-1:8] == lo[GRAN_W-1:8]);
    end

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        load    = 1'b0;
        ptr_d   = ptr_q;
        exact_d = exact_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_vld) begin
                    load    = 1'b1;
                    e_d     = '0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (fit) begin
                    state_d = StFinal;
                end else if (e_q == ExpLast) begin
                    e_d     = ExpUnb;
                    state_d = StFinal;
                end else begin
                    e_d = e_q + EXP_W'(1);
                end
            end
            StFinal: begin
                state_d                      = StDone;
                ptr_d[PTR_EXP_MSB:PTR_EXP_LSB] = e_q;
                ptr_d[PTR_ADDR_MSB:0]        = cursor_q;
                if (e_q == ExpUnb) begin
                    ptr_d[PTR_HI_MSB:PTR_HI_LSB]   = 7'h7f;
                    ptr_d[PTR_LOW_MSB:PTR_LOW_LSB] = 7'h00;
                    ptr_d[PTR_ON_LOW]              = 1'b1;
                    exact_d                        = 1'b0;
                    err_d                          = 1'b0;
                end else begin
                    ptr_d[PTR_HI_MSB:PTR_HI_LSB]   = hi[7:1];
                    ptr_d[PTR_LOW_MSB:PTR_LOW_LSB] = lo[7:1];
                    ptr_d[PTR_ON_LOW]              = cw_on_low;
                    exact_d                        = exact;
                    err_d                          = cw_err;
                end
            end
            StDone: begin
                if (out_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            e_q      <= '0;
            b_q      <= '0;
            t_q      <= '0;
            zl_q     <= 1'b0;
            cursor_q <= '0;
            ptr_q    <= '0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            ptr_q   <= ptr_d;
            exact_q <= exact_d;
            err_q   <= err_d;
            if (load) begin
                b_q      <= in_base[ADDR_W-1:GRAN_LSB];
                // Exclusive end granule, rounded up; the 45-bit sum cannot wrap.
                t_q      <= (GRAN_W + 1)'(({1'b0, in_base} + {1'b0, in_len} +
                                           (ADDR_W + 1)'(15)) >> GRAN_LSB);
                zl_q     <= (in_len == '0);
                cursor_q <= in_cursor;
            end
        end
    end

    assign in_rdy    = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_vld   = (state_q == StDone);
    assign out_ptr   = ptr_q;
    assign out_exact = exact_q;
    assign out_err   = err_q;

endmodule
